read_resp_merge: RTL and testbench
==================================

READ_RESP_MERGE -- requirements
Module: read_resp_merge

Interface
REQ-001 Parameter PLD_W, default 256: width of one RAM read-response payload.
REQ-002 Parameter FIFO_DEPTH, default 4: entries per RAM response FIFO; power of two, at least 2.
REQ-003 Parameter AFULL_LVL, default 2: occupancy at or above which the almost-full flag asserts; at most FIFO_DEPTH.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 ram_rd_vld  input  8  read-response valid from RAM k (k=0..7); no backpressure; fire-and-forget.
REQ-007 ram_rd_pld  input  8 x PLD_W  read-response payload from RAM k.
REQ-008 ram_rd_afull  output  8  RAM k FIFO occupancy >= AFULL_LVL; the upstream read issuer uses it to stop issuing to RAM k.
REQ-009 ch_rd_vld  output  4  merged response valid on hash channel i (i=0..3).
REQ-010 ch_rd_pld  output  4 x PLD_W  merged response payload on channel i.
REQ-011 ch_rd_rdy  input  4  downstream ready on channel i.
REQ-012 ram_rd_ovf_err  output  8  sticky overflow error per RAM FIFO (see REQ-027).

Function
REQ-013 Channel i shall merge responses from RAM 2i (even) and RAM 2i+1 (odd), inverting the 4-to-8 write fan-out by dest_ram_id[0].
REQ-014 Each RAM k shall own one FIFO_DEPTH-entry FIFO with a read pointer, a write pointer and an occupancy counter of width clog2(FIFO_DEPTH)+1; both pointers wrap modulo FIFO_DEPTH.
REQ-015 Push: ram_rd_vld[k]=1 and the FIFO not full, or full with a pop in the same cycle, shall write ram_rd_pld[k] at the write pointer.
REQ-016 Latency: a payload pushed in cycle N shall be visible on ch_rd_vld/ch_rd_pld no earlier than cycle N+1; there is no combinational path from ram_rd_* to ch_rd_*.
REQ-017 ch_rd_vld[i] shall be 1 iff FIFO 2i or FIFO 2i+1 is non-empty.
REQ-018 Arbitration: per channel, a 1-bit last-grant register.
- Only one FIFO non-empty: that FIFO is granted.
- Both non-empty: the FIFO not granted last is granted.
REQ-019 ch_rd_pld[i] shall be the head entry of the granted FIFO and shall stay stable while ch_rd_vld[i]=1 and ch_rd_rdy[i]=0.
REQ-020 Pop occurs only when ch_rd_vld[i]=1 and ch_rd_rdy[i]=1; the last-grant register updates only on a pop.
REQ-021 Per-RAM order shall be preserved; no ordering is guaranteed between RAM 2i and RAM 2i+1.
REQ-022 Simultaneous push and pop on one FIFO shall leave occupancy unchanged; this also holds at full and at empty.
REQ-023 Both RAMs of a channel pushing in the same cycle shall both be accepted, with no loss.
REQ-024 ram_rd_afull[k] shall be decoded combinationally from the registered occupancy counter.
REQ-025 Wrap-around: pointers shall roll from FIFO_DEPTH-1 to 0 with no bubble and no data loss.

Reset
REQ-026 While rst_n=0, all of the following shall be 0 asynchronously:
- pointers and occupancy counters;
- last-grant registers (even RAM wins the first tie);
- ch_rd_vld, ram_rd_afull and ram_rd_ovf_err.
Payload storage is not reset. A reset mid-burst discards all buffered entries.

Configuration
REQ-027 With macro READ_RESP_OVF_CHK_EN defined:
- a push attempt on a full FIFO with no same-cycle pop shall drop the payload and set ram_rd_ovf_err[k] until reset;
- a simulation assertion shall fire with $error.
REQ-028 Without READ_RESP_OVF_CHK_EN:
- ram_rd_ovf_err is tied to 0 and no assertion is compiled in;
- overflow pushes are still dropped, and pointers and occupancy are never corrupted.

Verification
REQ-029 Single: ram_rd_vld[2]=1, pld=0xA5 in cycle 0, ch_rd_rdy[1]=1 -> ch_rd_vld[1]=1 with pld 0xA5 in cycle 1 only.
REQ-030 Tie: RAM 0 pushes A,B and RAM 1 pushes C,D in the same cycles, ch_rd_rdy[0]=1 -> channel 0 outputs A,C,B,D.
REQ-031 Backpressure: ch_rd_rdy[3]=0 while RAM 7 pushes 2 entries (AFULL_LVL=2) -> ram_rd_afull[7]=1; pld stable; release -> both drained in order, afull clears.
REQ-032 Full plus simultaneous push/pop: RAM 4 FIFO at 4 entries, push and pop in the same cycle -> occupancy stays 4 and ram_rd_ovf_err[4]=0.
REQ-033 Overflow (macro on): 5 pushes to RAM 5 with rdy=0 -> 5th payload dropped, ram_rd_ovf_err[5]=1 until rst_n=0; macro off -> err stays 0 and output shows first 4 only.
REQ-034 Reset mid-burst: rst_n=0 with 3 entries buffered -> ch_rd_vld=0 immediately; after release, channel idle until a new push.

Source files
------------

// File: rtl/read_resp_merge.sv
// read_resp_merge: merges read responses from 8 RAMs onto 4 hash channels.
// Channel i drains the FIFOs of RAM 2i (even) and RAM 2i+1 (odd) with a
// round-robin arbiter that holds its choice while the channel is stalled.
// Optional feature macro: READ_RESP_OVF_CHK_EN (sticky overflow flags plus a
// simulation assertion on pushes into a full FIFO with no same-cycle pop).
module read_resp_merge #(
    parameter int PLD_W      = 256,
    parameter int FIFO_DEPTH = 4,
    parameter int AFULL_LVL  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           ram_rd_vld,
    input  logic [8*PLD_W-1:0]   ram_rd_pld,
    output logic [7:0]           ram_rd_afull,
    output logic [3:0]           ch_rd_vld,
    output logic [4*PLD_W-1:0]   ch_rd_pld,
    input  logic [3:0]           ch_rd_rdy,
    output logic [7:0]           ram_rd_ovf_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       w_nempty;
    logic [7:0]       w_push;
    logic [7:0]       w_pop;
    logic [PLD_W-1:0] w_head [8];

    // ------------------------------------------------------------------
    // Per-RAM response FIFOs
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 8; gi++) begin : g_fifo
        logic [PLD_W-1:0] r_mem [FIFO_DEPTH];
        logic [PTR_W-1:0] r_wptr;
        logic [PTR_W-1:0] r_rptr;
        logic [CNT_W-1:0] r_cnt;
        logic             w_full;

        assign w_full          = (r_cnt == CNT_W'(FIFO_DEPTH));
        assign w_nempty[gi]    = (r_cnt != '0);
        // A full FIFO still accepts a push when its head leaves this cycle.
        assign w_push[gi]      = ram_rd_vld[gi] & (~w_full | w_pop[gi]);
        assign ram_rd_afull[gi] = (r_cnt >= CNT_W'(AFULL_LVL));
        assign w_head[gi]      = r_mem[r_rptr];

        // Payload storage: written on accepted pushes, never reset.
        always_ff @(posedge clk) begin
            if (w_push[gi]) begin
                r_mem[r_wptr] <= ram_rd_pld[gi*PLD_W +: PLD_W];
            end
        end

        // Pointers wrap naturally (power-of-two depth); occupancy tracks push/pop.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_cnt  <= '0;
            end else begin
                if (w_push[gi]) begin
                    r_wptr <= r_wptr + PTR_W'(1);
                end
                if (w_pop[gi]) begin
                    r_rptr <= r_rptr + PTR_W'(1);
                end
                case ({w_push[gi], w_pop[gi]})
                    2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                    2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                    default: r_cnt <= r_cnt;
                endcase
            end
        end

`ifdef READ_RESP_OVF_CHK_EN
        logic w_ovf_try;
        logic r_ovf;

        assign w_ovf_try          = ram_rd_vld[gi] & w_full & ~w_pop[gi];
        assign ram_rd_ovf_err[gi] = r_ovf;

        // Sticky overflow flag: a dropped payload is remembered until reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_ovf <= 1'b0;
            end else if (w_ovf_try) begin
                r_ovf <= 1'b1;
            end
        end

        // Flag the dropped payload loudly in simulation.
        always_ff @(posedge clk) begin
            if (rst_n) begin
                assert (!w_ovf_try)
                    else $error("read_resp_merge: overflow on RAM %0d FIFO", gi);
            end
        end
`endif
    end

`ifndef READ_RESP_OVF_CHK_EN
    assign ram_rd_ovf_err = '0;
`endif

    // ------------------------------------------------------------------
    // Per-channel arbitration between the even and odd RAM FIFOs
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
        logic r_even_last;  // 1: even FIFO won the last pop
        logic r_lock;       // channel was stalled last cycle; keep the grant
        logic r_lock_odd;   // grant held while locked
        logic w_arb_odd;
        logic w_sel_odd;
        logic w_pop_ch;

        // Odd wins if it is the only one waiting, or on a tie after an even pop.
        assign w_arb_odd = w_nempty[2*gi+1] & (~w_nempty[2*gi] | r_even_last);
        // While stalled, the presented payload must not switch FIFOs.
        assign w_sel_odd = r_lock ? r_lock_odd : w_arb_odd;

        assign ch_rd_vld[gi] = w_nempty[2*gi] | w_nempty[2*gi+1];
        assign w_pop_ch      = ch_rd_vld[gi] & ch_rd_rdy[gi];
        assign w_pop[2*gi]   = w_pop_ch & ~w_sel_odd;
        assign w_pop[2*gi+1] = w_pop_ch & w_sel_odd;
        assign ch_rd_pld[gi*PLD_W +: PLD_W] = w_sel_odd ? w_head[2*gi+1] : w_head[2*gi];

        // Last-grant update on pops; grant lock follows the stall condition.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_even_last <= 1'b0;
                r_lock      <= 1'b0;
                r_lock_odd  <= 1'b0;
            end else begin
                if (w_pop_ch) begin
                    r_even_last <= ~w_sel_odd;
                end
                r_lock     <= ch_rd_vld[gi] & ~ch_rd_rdy[gi];
                r_lock_odd <= w_sel_odd;
            end
        end
    end

endmodule

// File: tb/tb_read_resp_merge.sv
// tb_read_resp_merge: directed self-checking bench for read_resp_merge.
module tb_read_resp_merge;

    localparam int PW = 256;
`ifdef READ_RESP_OVF_CHK_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic [7:0]        ram_rd_vld;
    logic [8*PW-1:0]   ram_rd_pld;
    logic [7:0]        ram_rd_afull;
    logic [3:0]        ch_rd_vld;
    logic [4*PW-1:0]   ch_rd_pld;
    logic [3:0]        ch_rd_rdy;
    logic [7:0]        ram_rd_ovf_err;

    int checks = 0;
    int errors = 0;

    read_resp_merge #(.PLD_W(PW), .FIFO_DEPTH(4), .AFULL_LVL(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ram_rd_vld     (ram_rd_vld),
        .ram_rd_pld     (ram_rd_pld),
        .ram_rd_afull   (ram_rd_afull),
        .ch_rd_vld      (ch_rd_vld),
        .ch_rd_pld      (ch_rd_pld),
        .ch_rd_rdy      (ch_rd_rdy),
        .ram_rd_ovf_err (ram_rd_ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] ch_pld(input int i);
        return ch_rd_pld[i*PW +: PW];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_set(input int k, input logic [PW-1:0] v);
        ram_rd_vld[k] = 1'b1;
        ram_rd_pld[k*PW +: PW] = v;
    endtask

    task automatic idle();
        ram_rd_vld = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (ch_rd_vld !== 4'b0 || ram_rd_afull !== 8'b0 || ram_rd_ovf_err !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs: got vld=%b afull=%b ovf=%b required all zero",
                     ch_rd_vld, ram_rd_afull, ram_rd_ovf_err);
        end
        rst_n = 1'b1;
        step();
        $display("reset: vld=%b afull=%b ovf=%b", ch_rd_vld, ram_rd_afull, ram_rd_ovf_err);
    endtask

    task automatic test_single();
        ch_rd_rdy = 4'b0010;
        push_set(2, PW'(8'hA5));
        #1;
        checks++;
        if (ch_rd_vld !== 4'b0000) begin
            errors++;
            $display("FAIL single_cycle0: got vld=%b required 0000", ch_rd_vld);
        end
        step();
        idle();
        #1;
        checks++;
        if (ch_rd_vld !== 4'b0010 || ch_pld(1) !== PW'(8'hA5)) begin
            errors++;
            $display("FAIL single_cycle1: got vld=%b pld=%h required 0010/a5", ch_rd_vld, ch_pld(1)[7:0]);
        end
        step();
        checks++;
        if (ch_rd_vld !== 4'b0000) begin
            errors++;
            $display("FAIL single_cycle2: got vld=%b required 0000", ch_rd_vld);
        end
        $display("single: done");
    endtask

    task automatic test_tie();
        logic [7:0] exp_seq [4];
        exp_seq = '{8'h0A, 8'h0C, 8'h0B, 8'h0D};
        ch_rd_rdy = 4'b0001;
        push_set(0, PW'(8'h0A));
        push_set(1, PW'(8'h0C));
        step();
        push_set(0, PW'(8'h0B));
        push_set(1, PW'(8'h0D));
        #1;
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (ch_rd_vld[0] !== 1'b1 || ch_pld(0) !== PW'(exp_seq[n])) begin
                errors++;
                $display("FAIL tie_order[%0d]: got vld=%b pld=%h required 1/%h",
                         n, ch_rd_vld[0], ch_pld(0)[7:0], exp_seq[n]);
            end
            $display("tie: beat %0d pld=%h", n, ch_pld(0)[7:0]);
            step();
            idle();
            #1;
        end
        checks++;
        if (ch_rd_vld[0] !== 1'b0) begin
            errors++;
            $display("FAIL tie_empty: got vld=%b required 0", ch_rd_vld[0]);
        end
    endtask

    task automatic test_backpressure();
        ch_rd_rdy = 4'b0000;
        push_set(7, PW'(8'h71));
        step();
        push_set(7, PW'(8'h72));
        step();
        idle();
        #1;
        checks++;
        if (ram_rd_afull[7] !== 1'b1 || ch_rd_vld[3] !== 1'b1 || ch_pld(3) !== PW'(8'h71)) begin
            errors++;
            $display("FAIL bp_afull: got afull=%b vld=%b pld=%h required 1/1/71",
                     ram_rd_afull[7], ch_rd_vld[3], ch_pld(3)[7:0]);
        end
        // even RAM joins during the stall; the presented payload must not change
        push_set(6, PW'(8'h61));
        step();
        idle();
        #1;
        checks++;
        if (ch_pld(3) !== PW'(8'h71)) begin
            errors++;
            $display("FAIL bp_stable: got pld=%h required 71", ch_pld(3)[7:0]);
        end
        ch_rd_rdy = 4'b1000;
        #1;
        checks++;
        if (ch_pld(3) !== PW'(8'h71)) begin
            errors++;
            $display("FAIL bp_release0: got pld=%h required 71", ch_pld(3)[7:0]);
        end
        step();
        checks++;
        if (ch_pld(3) !== PW'(8'h61) || ram_rd_afull[7] !== 1'b0) begin
            errors++;
            $display("FAIL bp_release1: got pld=%h afull=%b required 61/0", ch_pld(3)[7:0], ram_rd_afull[7]);
        end
        step();
        checks++;
        if (ch_pld(3) !== PW'(8'h72) || ch_rd_vld[3] !== 1'b1) begin
            errors++;
            $display("FAIL bp_release2: got pld=%h vld=%b required 72/1", ch_pld(3)[7:0], ch_rd_vld[3]);
        end
        step();
        checks++;
        if (ch_rd_vld[3] !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: got vld=%b required 0", ch_rd_vld[3]);
        end
        $display("backpressure: done");
    endtask

    task automatic test_full_pushpop();
        ch_rd_rdy = 4'b0000;
        for (int v = 8'h41; v <= 8'h44; v++) begin
            push_set(4, PW'(v));
            step();
        end
        idle();
        #1;
        checks++;
        if (ram_rd_afull[4] !== 1'b1 || ch_pld(2) !== PW'(8'h41)) begin
            errors++;
            $display("FAIL full_fill: got afull=%b pld=%h required 1/41", ram_rd_afull[4], ch_pld(2)[7:0]);
        end
        push_set(4, PW'(8'h45));
        ch_rd_rdy = 4'b0100;
        step();
        idle();
        ch_rd_rdy = 4'b0000;
        #1;
        checks++;
        if (ram_rd_ovf_err[4] !== 1'b0 || ch_pld(2) !== PW'(8'h42)) begin
            errors++;
            $display("FAIL full_pushpop: got ovf=%b pld=%h required 0/42", ram_rd_ovf_err[4], ch_pld(2)[7:0]);
        end
        ch_rd_rdy = 4'b0100;
        #1;
        for (int v = 8'h42; v <= 8'h45; v++) begin
            checks++;
            if (ch_rd_vld[2] !== 1'b1 || ch_pld(2) !== PW'(v)) begin
                errors++;
                $display("FAIL full_drain: got vld=%b pld=%h required 1/%h", ch_rd_vld[2], ch_pld(2)[7:0], v[7:0]);
            end
            step();
        end
        checks++;
        if (ch_rd_vld[2] !== 1'b0) begin
            errors++;
            $display("FAIL full_empty: got vld=%b required 0 (occupancy not 4)", ch_rd_vld[2]);
        end
        $display("full_pushpop: done");
    endtask

    task automatic test_overflow();
        ch_rd_rdy = 4'b0000;
        for (int v = 8'h51; v <= 8'h55; v++) begin
            push_set(5, PW'(v));
            step();
        end
        idle();
        #1;
        checks++;
        if (ram_rd_ovf_err[5] !== EXP_OVF) begin
            errors++;
            $display("FAIL ovf_flag: got %b required %b", ram_rd_ovf_err[5], EXP_OVF);
        end
        ch_rd_rdy = 4'b0100;
        #1;
        for (int v = 8'h51; v <= 8'h54; v++) begin
            checks++;
            if (ch_rd_vld[2] !== 1'b1 || ch_pld(2) !== PW'(v)) begin
                errors++;
                $display("FAIL ovf_drain: got vld=%b pld=%h required 1/%h", ch_rd_vld[2], ch_pld(2)[7:0], v[7:0]);
            end
            step();
        end
        checks++;
        if (ch_rd_vld[2] !== 1'b0 || ram_rd_ovf_err[5] !== EXP_OVF) begin
            errors++;
            $display("FAIL ovf_dropped: got vld=%b ovf=%b required 0/%b", ch_rd_vld[2], ram_rd_ovf_err[5], EXP_OVF);
        end
        $display("overflow: ovf=%b", ram_rd_ovf_err);
    endtask

    task automatic test_reset_mid();
        ch_rd_rdy = 4'b0000;
        for (int v = 1; v <= 3; v++) begin
            push_set(0, PW'(v));
            step();
        end
        idle();
        #1;
        checks++;
        if (ch_rd_vld[0] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_buffered: got vld=%b required 1", ch_rd_vld[0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ch_rd_vld !== 4'b0 || ram_rd_afull !== 8'b0 || ram_rd_ovf_err !== 8'b0) begin
            errors++;
            $display("FAIL rstmid_async: got vld=%b afull=%b ovf=%b required all zero",
                     ch_rd_vld, ram_rd_afull, ram_rd_ovf_err);
        end
        step();
        step();
        rst_n = 1'b1;
        ch_rd_rdy = 4'b1111;
        step();
        step();
        checks++;
        if (ch_rd_vld !== 4'b0) begin
            errors++;
            $display("FAIL rstmid_idle: got vld=%b required 0000", ch_rd_vld);
        end
        push_set(1, PW'(8'h99));
        step();
        idle();
        #1;
        checks++;
        if (ch_rd_vld !== 4'b0001 || ch_pld(0) !== PW'(8'h99)) begin
            errors++;
            $display("FAIL rstmid_new: got vld=%b pld=%h required 0001/99", ch_rd_vld, ch_pld(0)[7:0]);
        end
        step();
        checks++;
        if (ch_rd_vld !== 4'b0) begin
            errors++;
            $display("FAIL rstmid_drained: got vld=%b required 0000", ch_rd_vld);
        end
        $display("reset_mid: done");
    endtask

    initial begin
        ram_rd_vld = '0;
        ram_rd_pld = '0;
        ch_rd_rdy  = '0;
        test_reset();
        test_single();
        test_tie();
        test_backpressure();
        test_full_pushpop();
        test_overflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
